rr_arbiter_mux: RTL and testbench
=================================

Name: rr_arbiter_mux

Overview:
- Round-robin arbiter that shares one downstream dti channel, typically a decouple buffer, among NUM requesting dti channels.
- Each accepted beat is tagged with the index of its source and held in a one-entry output register.
- With LOCK=1 the grant is held for a whole transaction, which ends on the beat whose eot bit (data MSB) is set, so that multi-beat transactions never interleave.
- Sits between parallel producers and a shared consumer resource.

Parameters:
- NUM, 4, number of requesting input channels (>=2; need not be a power of two).
- DIN, 16, input data width; bit DIN-1 is the eot flag when LOCK=1.
- LOCK, 1, 1 = hold grant until the eot beat; 0 = re-arbitrate after every beat.
- IDW (localparam), max(1,$clog2(NUM)), width of the source-index tag.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- din_data  input  NUM x DIN  per-requester data.
- din_valid  input  NUM  per-requester valid.
- din_ready  output  NUM  per-requester ready; at most one bit is high.
- dout_data  output  IDW+DIN  {source index, data}; index occupies the MSBs.
- dout_valid  output  1  output register holds a beat.
- dout_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset: dout_valid=0; rr pointer ptr=0; locked=0; lock_id=0. dout_data is don't-care while dout_valid=0.
- dti rules:
  - din_ready[i] may depend combinationally on din_valid and dout_ready.
  - dout_valid depends only on state.
  - A beat transfers on a cycle with valid&ready high at a clock edge.
- Load enable: ld = !dout_valid | dout_ready. This gives full throughput (one beat per cycle) with no bubble under backpressure release.
- Grant selection when unlocked:
  - g = the first index i with din_valid[i]=1, scanning ptr, ptr+1, ..., NUM-1, 0, ..., ptr-1 (mod NUM).
  - No valid input means no grant.
- Grant selection when locked: g = lock_id, considered only if din_valid[lock_id]=1. Other inputs are never granted, even if lock_id is idle.
- din_ready[g] = ld & grant_exists; all other din_ready bits are 0.
- On a transfer from g:
  - The output register loads {g, din_data[g]} and dout_valid<=1. Latency is 1 cycle from input transfer to dout_valid.
- Otherwise:
  - If dout_ready=1, dout_valid<=0.
  - If dout_ready=0, the register holds its contents.
- Lock and pointer update on a transfer with LOCK=1:
  - Eot bit =0: locked<=1, lock_id<=g, ptr unchanged.
  - Eot bit =1: locked<=0, ptr<=(g+1) mod NUM.
- Lock and pointer update on a transfer with LOCK=0: ptr<=(g+1) mod NUM every transfer; locked stays 0.
- Wrap: ptr=NUM-1 advances to 0. For a non-power-of-2 NUM the pointer never reaches NUM..2^IDW-1.
- Simultaneous events: a consumer take (dout_ready) and a new load in the same cycle is legal. The register is replaced and dout_valid stays 1.
- A single-beat transaction (eot=1 on the first beat) never sets locked.
- Reset mid-transaction clears lock and output immediately. Any in-flight beat in the register is discarded.
- Fairness: with all inputs continuously valid and LOCK=0, the grant sequence is 0,1,...,NUM-1,0,...

Decomposition:
- Shared package arb_pkg:
  - function id_width(n) returning max(1,$clog2(n)).
  - typedef for the tag/index type.
- Sub-module rr_pick (combinational):
  - Inputs: req[NUM], ptr.
  - Outputs: gnt_idx, gnt_vld.
  - Implemented as a double-width request vector rotated by ptr with a priority encoder; it is reusable by other schedulers.
- Lock and pointer registers, and the output register, live in rr_arbiter_mux.

Test Plan:
- Reset, then all din_valid=0 -> dout_valid=0, din_ready=0 for 4+ cycles; ptr=0.
- LOCK=0, NUM=4, all inputs valid with data=0x10+i, dout_ready=1 -> dout_data tags 0,1,2,3,0,... on consecutive cycles, one beat per cycle.
- LOCK=1:
  - Stimulus: input 2 sends 3 beats (eot on beat 3) while input 0 is held valid.
  - Required response: the output shows tags 2,2,2 then 0. Input 0 sees din_ready=0 throughout. ptr=3 after the eot beat.
- Backpressure: dout_ready=0 for 5 cycles with input 1 valid -> dout_valid=1 holding the first beat, din_ready=0. When dout_ready rises, the next beat is accepted in that same cycle with no bubble.
- NUM=3 wrap: only input 2 is valid and transfers (eot=1) -> ptr=0. Inputs 0 and 2 are then valid -> 0 is granted first.
- Reset asserted mid-lock (after beat 1 of 3 from input 1) -> dout_valid=0, locked cleared. Input 3 is then granted on the next cycle ahead of input 1, because scanning restarts at ptr=0 order and input 1 is invalid.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared helpers for the round-robin arbiter family: tag width and index type.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package arb_pkg;

    // Widest source tag any arbiter in this family is expected to carry.
    localparam int MAX_IDW = 8;

    // Generic source-index type for schedulers that do not size their own tag.
    typedef logic [MAX_IDW-1:0] arb_idx_t;

    // Tag width for n requesters; a lone bit is kept even for n <= 2.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter_mux_pick.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo NUM.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM = 4,
    parameter int IDW = id_width(NUM)
) (
    input  logic [NUM-1:0] req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] gnt_idx,
    output logic           gnt_vld
);

    logic [2*NUM-1:0] req_dbl;
    logic [NUM-1:0]   req_rot;
    int               off;
    int               sum;

    // Rotate a doubled request vector so ptr lands on bit 0, then find the lowest set bit.
    always_comb begin
        req_dbl = {req, req};
        req_rot = NUM'(req_dbl >> ptr);
        gnt_vld = 1'b0;
        off     = 0;
        for (int k = NUM - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                gnt_vld = 1'b1;
                off     = k;
            end
        end
        // Map the rotated offset back to an absolute index without a modulo operator.
        sum = int'(ptr) + off;
        if (sum >= NUM) begin
            sum = sum - NUM;
        end
        gnt_idx = IDW'(sum);
    end

endmodule

// File: rtl/rr_arbiter_mux.sv
// Round-robin N:1 dti mux; tags each beat with its source index, optional lock to eot.
// Latency: 1 cycle from input transfer to dout_valid; one beat per cycle sustained.
// Backpressure: loads only when the output register is empty or being drained this cycle.
module rr_arbiter_mux
    import arb_pkg::*;
#(
    parameter int NUM  = 4,
    parameter int DIN  = 16,
    parameter bit LOCK = 1'b1,
    localparam int IDW = id_width(NUM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM-1:0][DIN-1:0]  din_data,
    input  logic [NUM-1:0]           din_valid,
    output logic [NUM-1:0]           din_ready,
    output logic [IDW+DIN-1:0]       dout_data,
    output logic                     dout_valid,
    input  logic                     dout_ready
);

    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     lock_id_q, lock_id_d;
    logic               locked_q, locked_d;
    logic               dout_valid_q, dout_valid_d;
    logic [IDW+DIN-1:0] dout_data_q, dout_data_d;

    logic [IDW-1:0]     pick_idx;
    logic               pick_vld;
    logic [IDW-1:0]     g_idx;
    logic               g_vld;
    logic               ld;
    logic               xfer;
    logic               eot;
    logic [IDW-1:0]     ptr_nxt;

    rr_pick #(
        .NUM (NUM),
        .IDW (IDW)
    ) u_pick (
        .req     (din_valid),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    // The output slot can take a beat when empty or when its current beat leaves now.
    assign ld   = !dout_valid_q || dout_ready;
    assign xfer = ld && g_vld;
    assign eot  = din_data[g_idx][DIN-1];

    // While locked only the owner may be granted, even if it is momentarily idle.
    always_comb begin
        g_idx = pick_idx;
        g_vld = pick_vld;
        if (LOCK && locked_q) begin
            g_idx = lock_id_q;
            g_vld = din_valid[lock_id_q];
        end
    end

    // One-hot ready toward the granted requester only.
    always_comb begin
        din_ready = '0;
        for (int i = 0; i < NUM; i++) begin
            din_ready[i] = xfer && (g_idx == IDW'(i));
        end
    end

    // Next-state for pointer, lock and output register.
    always_comb begin
        ptr_d        = ptr_q;
        locked_d     = locked_q;
        lock_id_d    = lock_id_q;
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;
        ptr_nxt      = (g_idx == IDW'(NUM - 1)) ? '0 : g_idx + IDW'(1);
        if (xfer) begin
            dout_valid_d = 1'b1;
            dout_data_d  = {g_idx, din_data[g_idx]};
            if (LOCK && !eot) begin
                // Mid-transaction: keep the owner, leave the scan origin alone.
                locked_d  = 1'b1;
                lock_id_d = g_idx;
            end else begin
                // Transaction (or single beat) done: next scan starts after the winner.
                locked_d = 1'b0;
                ptr_d    = ptr_nxt;
            end
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; an in-flight beat is dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            locked_q     <= 1'b0;
            lock_id_q    <= '0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            locked_q     <= locked_d;
            lock_id_q    <= lock_id_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout_data  = dout_data_q;

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Bench for rr_arbiter_mux: three instances (NUM=4 locked, NUM=4 unlocked, NUM=3 locked).
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: dout_ready driven per scenario, randomized in the model-checked runs.
module tb_rr_arbiter_mux;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0][15:0] dat  [3];
    logic [3:0]       vld  [3];
    logic             ordy [3];

    logic [3:0]  a_rdy, b_rdy;
    logic [2:0]  c_rdy;
    logic [17:0] a_od, b_od, c_od;
    logic        a_ov, b_ov, c_ov;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arbiter_mux #(.NUM(4), .DIN(16), .LOCK(1'b1)) u_a (
        .clk(clk), .rst(rst), .din_data(dat[0]), .din_valid(vld[0]), .din_ready(a_rdy),
        .dout_data(a_od), .dout_valid(a_ov), .dout_ready(ordy[0]));

    rr_arbiter_mux #(.NUM(4), .DIN(16), .LOCK(1'b0)) u_b (
        .clk(clk), .rst(rst), .din_data(dat[1]), .din_valid(vld[1]), .din_ready(b_rdy),
        .dout_data(b_od), .dout_valid(b_ov), .dout_ready(ordy[1]));

    rr_arbiter_mux #(.NUM(3), .DIN(16), .LOCK(1'b1)) u_c (
        .clk(clk), .rst(rst), .din_data(dat[2][2:0]), .din_valid(vld[2][2:0]), .din_ready(c_rdy),
        .dout_data(c_od), .dout_valid(c_ov), .dout_ready(ordy[2]));

    function automatic logic [3:0] get_rdy(input int inst);
        case (inst)
            0:       return a_rdy;
            1:       return b_rdy;
            default: return {1'b0, c_rdy};
        endcase
    endfunction

    function automatic logic get_ov(input int inst);
        case (inst)
            0:       return a_ov;
            1:       return b_ov;
            default: return c_ov;
        endcase
    endfunction

    function automatic logic [17:0] get_od(input int inst);
        case (inst)
            0:       return a_od;
            1:       return b_od;
            default: return c_od;
        endcase
    endfunction

    task automatic clear_inputs();
        for (int n = 0; n < 3; n++) begin
            vld[n]  = '0;
            dat[n]  = '0;
            ordy[n] = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            #1;
            for (int n = 0; n < 3; n++) begin
                checks++;
                if (get_ov(n) !== 1'b0 || get_rdy(n) !== 4'b0) begin
                    errors++;
                    $display("FAIL reset_idle inst%0d cyc%0d: valid=%b ready=%b expected valid=0 ready=0000",
                             n, c, get_ov(n), get_rdy(n));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fairness();
        logic [17:0] exp_od;
        do_reset();
        vld[1] = 4'b1111;
        for (int i = 0; i < 4; i++) dat[1][i] = 16'h0010 + 16'(i);
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (b_rdy !== 4'(1 << (k % 4))) begin
                errors++;
                $display("FAIL fair_ready cyc%0d: got %b expected %b", k, b_rdy, 4'(1 << (k % 4)));
            end
            if (k > 0) begin
                exp_od = {2'((k - 1) % 4), 16'h0010 + 16'((k - 1) % 4)};
                checks++;
                if (b_ov !== 1'b1 || b_od !== exp_od) begin
                    errors++;
                    $display("FAIL fair_out cyc%0d: valid=%b data=%h expected valid=1 data=%h", k, b_ov, b_od, exp_od);
                end
            end
            @(negedge clk);
        end
        vld[1] = '0;
    endtask

    task automatic test_lock();
        logic [3:0]  exp_rdy [5];
        logic [17:0] exp_od  [5];
        exp_rdy = '{4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0000};
        exp_od  = '{18'h0, {2'd2, 16'h0001}, {2'd2, 16'h0002}, {2'd2, 16'h8003}, {2'd0, 16'h8000}};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: begin vld[0] = 4'b0100; dat[0][2] = 16'h0001; end
                1: begin vld[0] = 4'b0101; dat[0][2] = 16'h0002; dat[0][0] = 16'h8000; end
                2: dat[0][2] = 16'h8003;
                3: vld[0] = 4'b0001;
                default: vld[0] = 4'b0000;
            endcase
            #1;
            checks++;
            if (a_rdy !== exp_rdy[c]) begin
                errors++;
                $display("FAIL lock_ready cyc%0d: got %b expected %b", c, a_rdy, exp_rdy[c]);
            end
            if (c > 0) begin
                checks++;
                if (a_ov !== 1'b1 || a_od !== exp_od[c]) begin
                    errors++;
                    $display("FAIL lock_out cyc%0d: valid=%b data=%h expected valid=1 data=%h", c, a_ov, a_od, exp_od[c]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ordy[0] = 1'b0;
        vld[0] = 4'b0010;
        dat[0][1] = 16'h8001;
        #1;
        checks++;
        if (a_rdy !== 4'b0010) begin
            errors++;
            $display("FAIL bp_first_ready: got %b expected 0010", a_rdy);
        end
        @(negedge clk);
        dat[0][1] = 16'h8002;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (a_ov !== 1'b1 || a_od !== {2'd1, 16'h8001} || a_rdy !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: valid=%b data=%h ready=%b expected 1 %h 0000",
                         c, a_ov, a_od, a_rdy, {2'd1, 16'h8001});
            end
            @(negedge clk);
        end
        ordy[0] = 1'b1;
        #1;
        checks++;
        if (a_rdy !== 4'b0010 || a_od !== {2'd1, 16'h8001}) begin
            errors++;
            $display("FAIL bp_release: ready=%b data=%h expected 0010 %h", a_rdy, a_od, {2'd1, 16'h8001});
        end
        @(negedge clk);
        vld[0] = '0;
        #1;
        checks++;
        if (a_ov !== 1'b1 || a_od !== {2'd1, 16'h8002}) begin
            errors++;
            $display("FAIL bp_no_bubble: valid=%b data=%h expected 1 %h", a_ov, a_od, {2'd1, 16'h8002});
        end
        @(negedge clk);
    endtask

    task automatic test_wrap_num3();
        do_reset();
        vld[2] = 4'b0100;
        dat[2][2] = 16'h8022;
        #1;
        checks++;
        if (c_rdy !== 3'b100) begin
            errors++;
            $display("FAIL wrap_first: got %b expected 100", c_rdy);
        end
        @(negedge clk);
        vld[2] = 4'b0101;
        dat[2][0] = 16'h8020;
        #1;
        checks++;
        if (c_rdy !== 3'b001 || c_od !== {2'd2, 16'h8022}) begin
            errors++;
            $display("FAIL wrap_second: ready=%b data=%h expected 001 %h", c_rdy, c_od, {2'd2, 16'h8022});
        end
        @(negedge clk);
        vld[2] = '0;
        #1;
        checks++;
        if (c_ov !== 1'b1 || c_od !== {2'd0, 16'h8020}) begin
            errors++;
            $display("FAIL wrap_out: valid=%b data=%h expected 1 %h", c_ov, c_od, {2'd0, 16'h8020});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        vld[0] = 4'b0010;
        dat[0][1] = 16'h0001;
        #1;
        checks++;
        if (a_rdy !== 4'b0010) begin
            errors++;
            $display("FAIL midrst_beat1: got %b expected 0010", a_rdy);
        end
        @(negedge clk);
        rst = 1'b1;
        vld[0] = 4'b1000;
        dat[0][3] = 16'h8033;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (a_ov !== 1'b0 || a_rdy !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_after: valid=%b ready=%b expected 0 1000", a_ov, a_rdy);
        end
        @(negedge clk);
        vld[0] = '0;
        #1;
        checks++;
        if (a_ov !== 1'b1 || a_od !== {2'd3, 16'h8033}) begin
            errors++;
            $display("FAIL midrst_out: valid=%b data=%h expected 1 %h", a_ov, a_od, {2'd3, 16'h8033});
        end
        @(negedge clk);
    endtask

    // Randomized run against a transaction-level model of the arbitration rules.
    task automatic test_random(input int inst, input int cycles);
        int          num;
        bit          lk;
        int          ptr, lid, g, idx;
        bit          locked, ov, ld;
        logic [17:0] od;
        logic [3:0]  exp_rdy;
        logic [15:0] d;
        num = (inst == 2) ? 3 : 4;
        lk  = (inst != 1);
        ptr = 0; lid = 0; locked = 0; ov = 0; od = '0;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < 4; i++) begin
                d = 16'($urandom);
                d[15] = ($urandom_range(0, 2) == 0);
                dat[inst][i] = d;
                vld[inst][i] = (i < num) && ($urandom_range(0, 3) != 0);
            end
            ordy[inst] = ($urandom_range(0, 3) != 0);
            #1;
            ld = !ov || ordy[inst];
            g  = -1;
            if (lk && locked) begin
                if (vld[inst][lid]) g = lid;
            end else begin
                for (int k = 0; k < num; k++) begin
                    idx = (ptr + k) % num;
                    if (g < 0 && vld[inst][idx]) g = idx;
                end
            end
            exp_rdy = (ld && g >= 0) ? 4'(1 << g) : 4'b0;
            checks++;
            if (get_rdy(inst) !== exp_rdy) begin
                errors++;
                $display("FAIL rand_ready inst%0d cyc%0d: got %b expected %b", inst, c, get_rdy(inst), exp_rdy);
            end
            checks++;
            if (get_ov(inst) !== ov || (ov && get_od(inst) !== od)) begin
                errors++;
                $display("FAIL rand_out inst%0d cyc%0d: valid=%b data=%h expected valid=%b data=%h",
                         inst, c, get_ov(inst), get_od(inst), ov, od);
            end
            if (ld && g >= 0) begin
                ov = 1;
                od = {2'(g), dat[inst][g]};
                if (lk && !dat[inst][g][15]) begin
                    locked = 1;
                    lid    = g;
                end else begin
                    locked = 0;
                    ptr    = (g + 1) % num;
                end
            end else if (ordy[inst]) begin
                ov = 0;
            end
            @(negedge clk);
        end
        vld[inst] = '0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_fairness();
        test_lock();
        test_backpressure();
        test_wrap_num3();
        test_reset_mid_lock();
        test_random(0, 300);
        test_random(1, 300);
        test_random(2, 300);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
